// File: rtl/func_sweep_pkg.sv
// Shared state encoding and constants for the function-block sweep controller.
package func_sweep_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam int VEC_COUNT = 8;
  localparam int IDX_W     = 3;
  localparam logic [VEC_COUNT-1:0] FUNC_EXP_MASK = 8'h31;
endpackage

// File: rtl/func_sweep_timer.sv
// Settle down-counter: load arms it, expire fires on the SETTLE_CYCLES-th enabled cycle.
module func_sweep_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  logic [CNT_W-1:0] count;

  // Loaded with SETTLE_CYCLES-1 so that the cycle seeing zero is the last settle cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(SETTLE_CYCLES - 1);
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = en && (count == '0);
endmodule

// File: rtl/func_sweep_ctrl.sv
// In-system sweep of the 3-input function block: applies all {a,b,c}, captures y, checks it.
// Optional build macro FUNC_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module func_sweep_ctrl
  import func_sweep_pkg::*;
#(
  parameter int                   SETTLE_CYCLES = 2,
  parameter logic [VEC_COUNT-1:0] EXP_MASK      = FUNC_EXP_MASK
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  output logic                 a,
  output logic                 b,
  output logic                 c,
  input  logic                 y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [VEC_COUNT-1:0] capture,
  output logic                 fail_valid,
  output logic [IDX_W-1:0]     fail_idx
);
  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [VEC_COUNT-1:0] capture_next;
  logic                 mismatch;
  logic                 finish;
  logic                 timer_load;
  logic                 timer_expire;

  // pass must see the bit sampled on the very edge that enters DONE.
  always_comb begin
    capture_next      = capture;
    capture_next[idx] = y;
  end

  assign mismatch = (y != EXP_MASK[idx]);

`ifdef FUNC_SWEEP_STOP_ON_FAIL_EN
  assign finish = (idx == IDX_W'(VEC_COUNT - 1)) || mismatch;
`else
  assign finish = (idx == IDX_W'(VEC_COUNT - 1));
`endif

  assign timer_load = ((state == IDLE) && start && !abort) ||
                      ((state == SAMPLE) && !abort && !finish);

  func_sweep_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .en     (state == SETTLE),
    .expire (timer_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      {a, b, c}  <= 3'b000;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      capture    <= '0;
      fail_valid <= 1'b0;
      fail_idx   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state      <= SETTLE;
            idx        <= '0;
            {a, b, c}  <= 3'b000;
            busy       <= 1'b1;
            pass       <= 1'b0;
            capture    <= '0;
            fail_valid <= 1'b0;
            fail_idx   <= '0;
          end
        end
        SETTLE: begin
          if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            {a, b, c} <= 3'b000;
          end else if (timer_expire) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            {a, b, c} <= 3'b000;
          end else begin
            capture <= capture_next;
            if (mismatch && !fail_valid) begin
              fail_valid <= 1'b1;
              fail_idx   <= idx;
            end
            if (finish) begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              {a, b, c} <= 3'b000;
              pass      <= (capture_next == EXP_MASK);
            end else begin
              state     <= SETTLE;
              idx       <= idx + 1'b1;
              {a, b, c} <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_func_sweep_ctrl.sv
// Self-checking bench for func_sweep_ctrl: cycle model from sweep arithmetic plus directed literals.
module tb_func_sweep_ctrl;
  localparam int         S    = 2;
  localparam int         P    = S + 1;
  localparam logic [7:0] MASK = 8'h31;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       a, b, c, y;
  logic       busy, done, pass, fail_valid;
  logic [7:0] capture;
  logic [2:0] fail_idx;
  logic [1:0] mode = 2'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  func_sweep_ctrl #(
    .SETTLE_CYCLES (S),
    .EXP_MASK      (MASK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .a          (a),
    .b          (b),
    .c          (c),
    .y          (y),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .capture    (capture),
    .fail_valid (fail_valid),
    .fail_idx   (fail_idx)
  );

  // mode 0: correct function block, 1: y stuck 0, 2: y stuck 1
  assign y = (mode == 2'd0) ? ((~b & ~c) | (a & ~b)) : (mode == 2'd2);

  function automatic logic ref_y(input logic [1:0] md, input logic [2:0] v);
    logic fa, fb, fc;
    fa = v[2];
    fb = v[1];
    fc = v[0];
    if (md == 2'd0) return (~fb & ~fc) | (fa & ~fb);
    else if (md == 2'd1) return 1'b0;
    else return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: k = cycle number within the sweep (1..8P while busy, 0 otherwise).
  int         k = 0;
  logic       m_done = 1'b0;
  logic [7:0] m_cap = 8'h00;
  logic       m_pass = 1'b0;
  logic       m_fv = 1'b0;
  logic [2:0] m_fi = 3'd0;
  logic [7:0] mask_v = MASK;
  logic [2:0] vi;
  logic       yy;
  bit         fin;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k = 0; m_done = 1'b0; m_cap = 8'h00; m_pass = 1'b0; m_fv = 1'b0; m_fi = 3'd0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (k == 0) begin
      if (start && !abort) begin
        k = 1; m_cap = 8'h00; m_pass = 1'b0; m_fv = 1'b0; m_fi = 3'd0;
      end
    end else if (abort) begin
      k = 0;
    end else begin
      fin = (k == 8 * P);
      if (k % P == 0) begin
        vi = 3'(k / P - 1);
        yy = ref_y(mode, vi);
        m_cap[vi] = yy;
        if (yy != mask_v[vi]) begin
          if (!m_fv) begin
            m_fv = 1'b1;
            m_fi = vi;
          end
`ifdef FUNC_SWEEP_STOP_ON_FAIL_EN
          fin = 1'b1;
`endif
        end
      end
      if (fin) begin
        k = 0;
        m_done = 1'b1;
        m_pass = (m_cap == mask_v);
      end else begin
        k++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy",       busy,       k != 0);
      chk("done",       done,       m_done);
      chk("abc",        {a, b, c},  (k != 0) ? 3'((k - 1) / P) : 3'd0);
      chk("capture",    capture,    m_cap);
      chk("pass",       pass,       m_pass);
      chk("fail_valid", fail_valid, m_fv);
      chk("fail_idx",   fail_idx,   m_fv ? m_fi : fail_idx);
    end
  end

  task automatic run_sweep(input logic [1:0] md, input bit extra_start,
                           output int done_cyc, output int busy_cnt);
    @(posedge clk); #1;
    mode  = md;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_cyc = -1;
    busy_cnt = 0;
    for (int i = 1; i <= 200 && done_cyc < 0; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) done_cyc = i;
      if (extra_start && i == 5) begin #1 start = 1'b1; end
      if (extra_start && i == 6) begin #1 start = 1'b0; end
    end
    $display("sweep mode=%0d done_cycle=%0d busy=%0d capture=%02h pass=%0b fail_valid=%0b fail_idx=%0d",
             md, done_cyc, busy_cnt, capture, pass, fail_valid, fail_idx);
  endtask

  int dc, bc, done_seen;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {a, b, c, busy, done, pass, fail_valid, fail_idx, capture}, 32'd0);

    // correct block
    run_sweep(2'd0, 1'b0, dc, bc);
    chk("good_done_cycle", dc, 25);
    chk("good_busy_cycles", bc, 24);
    chk("good_capture", capture, 8'h31);
    chk("good_pass", pass, 1'b1);
    chk("good_fail_valid", fail_valid, 1'b0);

    // y stuck at 0
    run_sweep(2'd1, 1'b0, dc, bc);
    chk("y0_capture", capture, 8'h00);
    chk("y0_fail", {fail_valid, fail_idx}, {1'b1, 3'd0});
    chk("y0_pass", pass, 1'b0);
`ifdef FUNC_SWEEP_STOP_ON_FAIL_EN
    chk("y0_done_cycle", dc, 4);
`else
    chk("y0_done_cycle", dc, 25);
`endif

    // y stuck at 1
    run_sweep(2'd2, 1'b0, dc, bc);
    chk("y1_fail", {fail_valid, fail_idx}, {1'b1, 3'd1});
    chk("y1_pass", pass, 1'b0);
`ifdef FUNC_SWEEP_STOP_ON_FAIL_EN
    chk("y1_done_cycle", dc, 7);
    chk("y1_capture", capture, 8'h03);
`else
    chk("y1_done_cycle", dc, 25);
    chk("y1_capture", capture, 8'hFF);
`endif

    // start and abort together in IDLE
    @(posedge clk); #1;
    mode = 2'd0; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    chk("start_abort_busy", busy, 1'b0);
    #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_idle", busy, 1'b0);
    $display("start+abort in idle: busy=%0b", busy);

    // spurious start while busy
    run_sweep(2'd0, 1'b1, dc, bc);
    chk("restart_done_cycle", dc, 25);
    chk("restart_pass", pass, 1'b1);

    // abort while idx=3 is settling
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(negedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_abc", {a, b, c}, 3'd0);
    chk("abort_capture", capture, 8'h01);
    chk("abort_fail_valid", fail_valid, 1'b0);
    #1 abort = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);
    $display("abort at idx3: capture=%02h done_seen=%0d", capture, done_seen);
    run_sweep(2'd0, 1'b0, dc, bc);
    chk("after_abort_pass", {pass, capture}, {1'b1, 8'h31});

    // asynchronous reset mid-SETTLE at idx=5
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (16) @(negedge clk);
    chk("pre_reset_abc", {a, b, c}, 3'd5);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs", {a, b, c, busy, done, pass, fail_valid, fail_idx, capture}, 32'd0);
    $display("async reset at idx5: busy=%0b capture=%02h", busy, capture);
    @(posedge clk); #1 rst = 1'b0;
    run_sweep(2'd0, 1'b0, dc, bc);
    chk("after_reset_done_cycle", dc, 25);
    chk("after_reset_pass", {pass, capture, fail_valid}, {1'b1, 8'h31, 1'b0});

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/func_sweep_ctrl.md
# func_sweep_ctrl

Sequencer that exercises the three-input combinational function block (y = ~b·~c + a·~b) in-system. On a start request it walks the inputs {a,b,c} through all eight combinations and waits a programmable settle time per vector. It then samples y, builds an 8-bit captured truth table and compares it against the expected mask, reporting pass/fail and the first failing vector. It sits between a host/status register interface and one instance of the function block.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling y; legal range 1..255.
- `EXP_MASK`, default 8'h31: expected truth table; bit i = expected y for vector index i = {a,b,c}.
- `clk`, in, 1: single clock; all state updates on rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: begin a sweep; sampled only in IDLE.
- `abort`, in, 1: terminate a running sweep.
- `a`, `b`, `c`, out, 1 each: drive the function block inputs; registered.
- `y`, in, 1: function block output.
- `busy`, out, 1: sweep in progress.
- `done`, out, 1: one-cycle pulse when a sweep completes (not on abort).
- `pass`, out, 1: capture matched `EXP_MASK`; valid from `done` until next start.
- `capture`, out, 8: sampled truth table; bit i = y sampled for vector i.
- `fail_valid`, out, 1: at least one mismatch seen in the current/last sweep.
- `fail_idx`, out, 3: index of the first mismatching vector; valid when `fail_valid`.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - `start` & ~`abort`: idx←0, settle count←0, clear `capture`/`pass`/`fail_valid`/`fail_idx`, go to SETTLE.
  - `start` & `abort` in the same cycle: stay in IDLE (abort wins).
- Inputs:
  - {a,b,c} = idx (a = idx[2], c = idx[0]) while in SETTLE/SAMPLE.
  - {a,b,c} = 0 in IDLE and DONE.
- SETTLE: count increments each cycle; at count == SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE:
  - capture[idx]←y.
  - If y ≠ EXP_MASK[idx] and ~fail_valid: fail_valid←1, fail_idx←idx.
  - idx == 7: go to DONE.
  - Otherwise: idx←idx+1, count←0, go to SETTLE.
- idx is 3-bit. The 7→0 wrap never occurs because DONE is taken at idx 7.
- DONE: one cycle with `done`=1. pass←(capture == EXP_MASK), using the fully updated capture. Then IDLE.
- `abort` in SETTLE/SAMPLE: IDLE on next edge, no `done`, `pass` stays 0. `capture`/`fail_*` keep partial results.
- `abort` in DONE: ignored, DONE completes.
- `start` while not IDLE: ignored.
- Reset, asynchronous and at any point including mid-sweep: state IDLE, idx 0, count 0. All outputs 0: a, b, c, busy, done, pass, capture = 8'h00, fail_valid, fail_idx = 0.

## Timing
- `start` sampled at edge 0: busy=1 and {a,b,c}=000 from edge 0 onward.
- Each vector is held SETTLE_CYCLES+1 cycles; y is sampled at the end of the last held cycle.
- Total busy time is 8·(SETTLE_CYCLES+1) cycles. `done` is asserted in the following cycle, while busy=0.
- With default SETTLE_CYCLES=2: busy for 24 cycles, `done` in cycle 25 after start.
- `pass` is updated at the same edge `done` rises, and `done` is high for exactly one cycle.
- `abort` sampled at edge n: busy=0 and {a,b,c}=000 after edge n.

## Configuration
- `FUNC_SWEEP_STOP_ON_FAIL_EN` defined: the first mismatch in SAMPLE jumps directly to DONE (pass=0); remaining vectors are not applied and their capture bits stay 0.
- Undefined: all eight vectors are always applied. `fail_idx` still reports the first mismatch.

## Structure
- Package `func_sweep_pkg`:
  - state enum (IDLE/SETTLE/SAMPLE/DONE)
  - `VEC_COUNT` = 8, `IDX_W` = 3
  - `FUNC_EXP_MASK` = 8'h31, the default for `EXP_MASK`
- One sub-module, `func_sweep_timer`: settle down-counter with load/expire. Width $clog2(SETTLE_CYCLES+1), and `expire` pulses after SETTLE_CYCLES cycles.

## Test plan
- Correct function block attached, SETTLE_CYCLES=2, start pulse -> busy 24 cycles, done in cycle 25, capture=8'h31, pass=1, fail_valid=0.
- y tied 0 -> capture=8'h00, fail_idx=0, fail_valid=1, pass=0; without macro done still at cycle 25.
- y tied 1, macro defined -> fail at idx 1, done at cycle 7 (2 vectors × 3 cycles + 1), capture=8'h03, pass=0.
- abort asserted while idx=3 -> busy low next cycle, {a,b,c}=000, no done, capture bits 0..2 = 1,0,0; start again -> fresh full sweep passes.
- start and abort together in IDLE, and start while busy -> no state change / sweep timing unaffected.
- rst asserted mid-SETTLE at idx=5 -> all outputs 0 immediately (asynchronously), IDLE after release; subsequent start passes.
